// File: rtl/switch_debounce_if.sv
// ----------------------------------------------------------------------------
// switch_debounce_if
//   Bundles the switch-conditioning signals exchanged between the board-side
//   driver (master) and the debounce controller (slave).
//
//   sw_raw       N_SW  raw asynchronous switch pins          (master -> slave)
//   key_clear    1     one-cycle clear strobe from AHB slave (master -> slave)
//   switch_data  N_SW  debounced switch levels               (slave -> master)
//   sw_event     N_SW  sticky edge-event flags               (slave -> master)
//   irq          1     OR of sw_event                        (slave -> master)
// ----------------------------------------------------------------------------
interface switch_debounce_if #(
    parameter int N_SW = 4
);
    logic [N_SW-1:0] sw_raw;
    logic            key_clear;
    logic [N_SW-1:0] switch_data;
    logic [N_SW-1:0] sw_event;
    logic            irq;

    modport master (
        output sw_raw,
        output key_clear,
        input  switch_data,
        input  sw_event,
        input  irq
    );

    modport slave (
        input  sw_raw,
        input  key_clear,
        output switch_data,
        output sw_event,
        output irq
    );
endinterface

// File: rtl/switch_debounce_ctrl.sv
// ----------------------------------------------------------------------------
// switch_debounce_ctrl
//   Conditions raw board switches for the AHB-Lite switch slave: two-flop
//   synchronisation, debouncing on a prescaled sample tick, sticky edge-event
//   flags and an interrupt line.
//
//   Ports
//     HCLK      in   system clock
//     HRESETn   in   asynchronous active-low reset
//     bus       switch_debounce_if.slave
//                 sw_raw, key_clear             (in)
//                 switch_data, sw_event, irq    (out)
//
//   Parameters
//     N_SW        number of switch inputs (must match the interface width)
//     PRESCALE    HCLK cycles per sample tick (>=1)
//     STABLE_CNT  consecutive differing samples to accept a new level (>=1)
//
//   Build option
//     SWDB_FALL_EDGE_EN  when defined, falling level changes also set sw_event;
//                        otherwise only rising changes do.
// ----------------------------------------------------------------------------
module switch_debounce_ctrl #(
    parameter int N_SW       = 4,
    parameter int PRESCALE   = 50000,
    parameter int STABLE_CNT = 4
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    switch_debounce_if.slave  bus
);

    localparam int PS_W  = (PRESCALE   > 1) ? $clog2(PRESCALE)   : 1;
    localparam int CNT_W = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;

    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

    logic [N_SW-1:0]             r_sync1;
    logic [N_SW-1:0]             r_sync2;
    logic [PS_W-1:0]             r_ps_cnt;
    logic [N_SW-1:0]             r_level;
    logic [N_SW-1:0][CNT_W-1:0]  r_cnt;
    logic [N_SW-1:0]             r_edge;
    logic [N_SW-1:0]             r_event;
    logic                        r_irq;

    logic                        w_tick;
    logic [N_SW-1:0]             w_accept;
    logic [N_SW-1:0]             w_qual;
    logic [N_SW-1:0]             w_event_nxt;

    // Two-flop synchroniser; r_sync2 is the only copy the rest of the logic sees.
    // NOTE: every flop here uses an asynchronous active-low reset and
    // non-blocking assignments, so all state updates together at the edge.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= bus.sw_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Free-running prescaler; with PRESCALE=1 it stays at 0 and ticks every cycle.
    assign w_tick = (r_ps_cnt == PS_LAST);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_ps_cnt <= '0;
        end else if (w_tick) begin
            r_ps_cnt <= '0;
        end else begin
            r_ps_cnt <= r_ps_cnt + 1'b1;
        end
    end

    // A bit flips on the tick that brings its run of differing samples to STABLE_CNT.
    // NOTE: combinational outputs get a default first so no latch is inferred.
    always_comb begin
        w_accept = '0;
        for (int i = 0; i < N_SW; i++) begin
            w_accept[i] = w_tick && (r_sync2[i] != r_level[i]) && (r_cnt[i] == CNT_LAST);
        end
    end

`ifdef SWDB_FALL_EDGE_EN
    assign w_qual = w_accept;
`else
    // The accepted new level equals r_sync2, so a rising change is accept & sync.
    assign w_qual = w_accept & r_sync2;
`endif

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_level <= '0;
            r_cnt   <= '0;
            r_edge  <= '0;
        end else begin
            r_edge <= w_qual;
            if (w_tick) begin
                for (int i = 0; i < N_SW; i++) begin
                    if (r_sync2[i] == r_level[i]) begin
                        // Any sample agreeing with the current level discards the run.
                        r_cnt[i] <= '0;
                    end else if (r_cnt[i] == CNT_LAST) begin
                        r_level[i] <= r_sync2[i];
                        r_cnt[i]   <= '0;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

    // Set has priority over clear so an edge coinciding with key_clear survives.
    assign w_event_nxt = (r_event & ~{N_SW{bus.key_clear}}) | r_edge;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_event <= '0;
            r_irq   <= 1'b0;
        end else begin
            r_event <= w_event_nxt;
            r_irq   <= |w_event_nxt;
        end
    end

    assign bus.switch_data = r_level;
    assign bus.sw_event    = r_event;
    assign bus.irq         = r_irq;

endmodule

// File: tb/tb_switch_debounce_ctrl.sv
// ----------------------------------------------------------------------------
// tb_switch_debounce_ctrl
//   Scoreboard bench for switch_debounce_ctrl with PRESCALE=4, STABLE_CNT=3,
//   N_SW=4. Stimulus pushes every expected output change (values plus the
//   cycle window it must land in); a monitor pops one entry per observed
//   change of {switch_data, sw_event, irq} and compares.
//   Honours SWDB_FALL_EDGE_EN the same way the design does.
// ----------------------------------------------------------------------------
module tb_switch_debounce_ctrl;

    localparam int N_SW       = 4;
    localparam int PRESCALE   = 4;
    localparam int STABLE_CNT = 3;

    typedef struct {
        logic [N_SW-1:0] data;
        logic [N_SW-1:0] evt;
        logic            irq;
        int              min_cyc;   // earliest cycle allowed, -1 = unchecked
        int              max_cyc;   // latest cycle allowed,   -1 = unchecked
        int              rel;       // exact cycles after previous change, -1 = unchecked
    } exp_t;

    logic HCLK;
    logic HRESETn;

    switch_debounce_if #(.N_SW(N_SW)) bus ();

    switch_debounce_ctrl #(
        .N_SW       (N_SW),
        .PRESCALE   (PRESCALE),
        .STABLE_CNT (STABLE_CNT)
    ) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;
    int   last_chg = 0;
    logic [2*N_SW:0] prev_out = '0;

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    always @(posedge HCLK) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic check_range(input string name, input int got, input int lo, input int hi);
        n_checks++;
        if (got < lo || got > hi) begin
            n_errors++;
            $display("FAIL %s: got cycle %0d, expected %0d..%0d", name, got, lo, hi);
        end
    endtask

    task automatic push_exp(input logic [N_SW-1:0] data, input logic [N_SW-1:0] evt,
                            input logic irq, input int min_cyc, input int max_cyc,
                            input int rel);
        exp_t e;
        e.data    = data;
        e.evt     = evt;
        e.irq     = irq;
        e.min_cyc = min_cyc;
        e.max_cyc = max_cyc;
        e.rel     = rel;
        sb.push_back(e);
    endtask

    // Bounded wait for the monitor to consume every outstanding expectation.
    task automatic wait_drain(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (sb.size() == 0) break;
            @(negedge HCLK);
        end
        check(name, sb.size(), 0);
        sb.delete();
    endtask

    // Monitor: every change of the observable outputs must match the queue head.
    always @(negedge HCLK) begin
        logic [2*N_SW:0] cur;
        exp_t e;
        cur = {bus.switch_data, bus.sw_event, bus.irq};
        if (cur !== prev_out) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_change: got data=%b evt=%b irq=%b, expected no change (cycle %0d)",
                         bus.switch_data, bus.sw_event, bus.irq, cyc);
            end else begin
                e = sb.pop_front();
                check("switch_data", int'(bus.switch_data), int'(e.data));
                check("sw_event",    int'(bus.sw_event),    int'(e.evt));
                check("irq",         int'(bus.irq),         int'(e.irq));
                if (e.min_cyc >= 0 || e.max_cyc >= 0) begin
                    check_range("change_time", cyc,
                                (e.min_cyc >= 0) ? e.min_cyc : 0,
                                (e.max_cyc >= 0) ? e.max_cyc : 32'h7fff_ffff);
                end
                if (e.rel >= 0) begin
                    check("change_spacing", cyc - last_chg, e.rel);
                end
            end
            last_chg = cyc;
            prev_out = cur;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  t0;
        bit  found;

        HRESETn       = 1'b0;
        bus.sw_raw    = '0;
        bus.key_clear = 1'b0;
        repeat (3) @(negedge HCLK);
        HRESETn = 1'b1;

        // 1. Idle after reset: everything stays 0.
        repeat (40) @(negedge HCLK);
        check("reset_switch_data", int'(bus.switch_data), 0);
        check("reset_sw_event",    int'(bus.sw_event),    0);
        check("reset_irq",         int'(bus.irq),         0);

        // 2. Bit0 rises: level within 2+12 cycles (not before the 3rd sampling tick),
        //    event and irq exactly one cycle later.
        bus.sw_raw = 4'b0001;
        t0 = cyc;
        push_exp(4'b0001, 4'b0000, 1'b0, t0 + 11, t0 + 14, -1);
        push_exp(4'b0001, 4'b0001, 1'b1, -1, -1, 1);
        wait_drain("drain_rise_bit0", 40);

        // 3. Bit1 bounce of two sample periods: no change at all.
        bus.sw_raw[1] = 1'b1;
        repeat (2 * PRESCALE) @(negedge HCLK);
        bus.sw_raw[1] = 1'b0;
        repeat (24) @(negedge HCLK);
        check("glitch_switch_data1", int'(bus.switch_data[1]), 0);
        check("glitch_sw_event1",    int'(bus.sw_event[1]),    0);

        // 4a. key_clear drops the pending flag and irq on the next edge.
        bus.key_clear = 1'b1;
        t0 = cyc;
        push_exp(4'b0001, 4'b0000, 1'b0, t0 + 1, t0 + 1, -1);
        @(negedge HCLK);
        bus.key_clear = 1'b0;
        wait_drain("drain_clear", 10);

        // 4b. key_clear in the cycle the bit2 edge pulse is live: set wins.
        bus.sw_raw[2] = 1'b1;
        t0 = cyc;
        push_exp(4'b0101, 4'b0000, 1'b0, t0 + 11, t0 + 14, -1);
        push_exp(4'b0101, 4'b0100, 1'b1, -1, -1, 1);
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge HCLK);
            if (bus.switch_data[2]) begin
                found = 1'b1;
                break;
            end
        end
        check("bit2_level_seen", int'(found), 1);
        bus.key_clear = 1'b1;
        @(negedge HCLK);
        bus.key_clear = 1'b0;
        wait_drain("drain_set_wins", 10);

        // 5. Bit0 falls: level follows; event only with falling edges enabled.
        bus.sw_raw[0] = 1'b0;
        t0 = cyc;
        push_exp(4'b0100, 4'b0100, 1'b1, t0 + 11, t0 + 14, -1);
`ifdef SWDB_FALL_EDGE_EN
        push_exp(4'b0100, 4'b0101, 1'b1, -1, -1, 1);
`endif
        wait_drain("drain_fall_bit0", 40);

        // 6. Bit0 back high so sw_event=0101, then a partial falling run (cnt=2).
        bus.sw_raw[0] = 1'b1;
        t0 = cyc;
`ifdef SWDB_FALL_EDGE_EN
        push_exp(4'b0101, 4'b0101, 1'b1, t0 + 11, t0 + 14, -1);
`else
        push_exp(4'b0101, 4'b0100, 1'b1, t0 + 11, t0 + 14, -1);
        push_exp(4'b0101, 4'b0101, 1'b1, -1, -1, 1);
`endif
        wait_drain("drain_rerise_bit0", 40);

        // Ten cycles cover exactly two sampling ticks of the new low level.
        bus.sw_raw[0] = 1'b0;
        repeat (10) @(negedge HCLK);

        // Asynchronous reset: outputs clear without waiting for an edge.
        t0 = cyc;
        push_exp(4'b0000, 4'b0000, 1'b0, -1, t0 + 1, -1);
        #1 HRESETn = 1'b0;
        #1;
        check("async_rst_switch_data", int'(bus.switch_data), 0);
        check("async_rst_sw_event",    int'(bus.sw_event),    0);
        check("async_rst_irq",         int'(bus.irq),         0);
        repeat (3) @(negedge HCLK);
        wait_drain("drain_reset", 5);

        // Release with bit2 still held high: counts restart from zero, so the
        // rise lands on the 3rd tick (12th edge) and is a genuine event.
        HRESETn = 1'b1;
        t0 = cyc;
        push_exp(4'b0100, 4'b0000, 1'b0, t0 + 12, t0 + 12, -1);
        push_exp(4'b0100, 4'b0100, 1'b1, -1, -1, 1);
        wait_drain("drain_powerup_rise", 40);
        repeat (20) @(negedge HCLK);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
